fetch_decode_stage: RTL and testbench

Front-end stage that owns the program counter, drives the synchronous instruction ROM, and holds the IF/ID instruction register. Its `instruction` output is the stream consumed by the decode/forwarding logic. Two events can replace the fetched instruction with a bubble:
- a load-use hazard, which needs one bubble and a replay;
- a taken branch reported by execute, which squashes the two wrong-path instructions.

---
 rtl/fetch_decode_stage.sv | 164 ++++++++++++++++
 tb/tb_fetch_decode_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage.sv
// Fetch stage: owns the PC, addresses the synchronous instruction ROM and holds the IF/ID register.
// Define FD_LOAD_USE_STALL_EN to build load-use detection with a one-bubble skid/replay.
module fetch_decode_stage #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] instruction,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  output logic        lu_stall,
  output logic        flushing
);

`ifdef FD_LOAD_USE_STALL_EN
  typedef enum logic [1:0] {BOOT, RUN, FLUSH, LU_REPLAY} state_t;
`else
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
`endif

  state_t      state, state_nx;
  logic [15:0] pc, pc_nx, fetch_pc_d;
  logic [15:0] ir_nx, ipc_nx;
  logic        ivld_nx, fl_nx;

  assign imem_addr = pc;

`ifdef FD_LOAD_USE_STALL_EN
  logic [15:0] skid, skid_nx, skid_pc, skid_pc_nx;
  logic        skid_vld, skid_vld_nx, lu_nx, hazard, rd_rs, rd_rt;
  logic [3:0]  in_op;

  assign in_op = imem_rdata[15:12];

  // Which source fields the incoming instruction actually reads.
  always_comb begin
    rd_rs = 1'b0;
    rd_rt = 1'b0;
    case (in_op)
      4'd0, 4'd5, 4'd6: begin rd_rs = 1'b1; rd_rt = 1'b1; end
      4'd1, 4'd3:       rd_rt = 1'b1;
      4'd4:             rd_rs = 1'b1;
      default: ;
    endcase
  end

  assign hazard = instr_valid && (instruction[15:12] == 4'd4) &&
                  ((rd_rs && (imem_rdata[11:9] == instruction[8:6])) ||
                   (rd_rt && (imem_rdata[8:6]  == instruction[8:6])));
`else
  assign lu_stall = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ir_nx    = instruction;
    ipc_nx   = instr_pc;
    ivld_nx  = instr_valid;
    fl_nx    = 1'b0;
`ifdef FD_LOAD_USE_STALL_EN
    skid_nx     = skid;
    skid_pc_nx  = skid_pc;
    skid_vld_nx = skid_vld;
    lu_nx       = 1'b0;
`endif
    // Branch redirect beats everything; BOOT has no valid fetch to squash.
    if (branch_taken && (state != BOOT)) begin
      pc_nx    = branch_target;
      ir_nx    = NOP_WORD;
      ivld_nx  = 1'b0;
      fl_nx    = 1'b1;
      state_nx = FLUSH;
`ifdef FD_LOAD_USE_STALL_EN
      skid_vld_nx = 1'b0;
`endif
    end else begin
      case (state)
        BOOT: begin
          ir_nx    = NOP_WORD;
          ivld_nx  = 1'b0;
          pc_nx    = pc + 16'd1;
          state_nx = RUN;
        end
        RUN: begin
`ifdef FD_LOAD_USE_STALL_EN
          // Park the dependent word and hold the PC so its successor is re-fetched.
          if (hazard) begin
            ir_nx       = NOP_WORD;
            ivld_nx     = 1'b0;
            skid_nx     = imem_rdata;
            skid_pc_nx  = fetch_pc_d;
            skid_vld_nx = 1'b1;
            lu_nx       = 1'b1;
            state_nx    = LU_REPLAY;
          end else
`endif
          begin
            ir_nx   = imem_rdata;
            ipc_nx  = fetch_pc_d;
            ivld_nx = 1'b1;
            pc_nx   = pc + 16'd1;
          end
        end
        FLUSH: begin
          ir_nx    = NOP_WORD;
          ivld_nx  = 1'b0;
          fl_nx    = 1'b1;
          pc_nx    = pc + 16'd1;
          state_nx = RUN;
        end
`ifdef FD_LOAD_USE_STALL_EN
        LU_REPLAY: begin
          ir_nx       = skid;
          ipc_nx      = skid_pc;
          ivld_nx     = skid_vld;
          skid_vld_nx = 1'b0;
          pc_nx       = pc + 16'd1;
          state_nx    = RUN;
        end
`endif
        default: state_nx = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      pc          <= PC_RESET;
      fetch_pc_d  <= PC_RESET;
      instruction <= NOP_WORD;
      instr_pc    <= 16'h0000;
      instr_valid <= 1'b0;
      flushing    <= 1'b0;
`ifdef FD_LOAD_USE_STALL_EN
      lu_stall    <= 1'b0;
      skid        <= NOP_WORD;
      skid_pc     <= 16'h0000;
      skid_vld    <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      fetch_pc_d  <= pc;
      instruction <= ir_nx;
      instr_pc    <= ipc_nx;
      instr_valid <= ivld_nx;
      flushing    <= fl_nx;
`ifdef FD_LOAD_USE_STALL_EN
      lu_stall    <= lu_nx;
      skid        <= skid_nx;
      skid_pc     <= skid_pc_nx;
      skid_vld    <= skid_vld_nx;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_decode_stage;
  localparam logic [15:0] PC_RST = 16'h0010;
  localparam logic [15:0] NOP    = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] imem_addr, imem_rdata, branch_target, instruction, instr_pc;
  logic        branch_taken, instr_valid, lu_stall, flushing;
  logic [15:0] rom [0:65535];

  typedef struct {
    logic [15:0] instr, pc, addr;
    logic        vld, lu, fl, chk_pc, chk_addr;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0, n_err = 0, n_id = 0;

  fetch_decode_stage #(.PC_RESET(PC_RST), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .lu_stall(lu_stall), .flushing(flushing)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for the presented address arrives one cycle later.
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %h want %h", name, id, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("instruction", e.id, instruction, e.instr);
        chk("instr_valid", e.id, 16'(instr_valid), 16'(e.vld));
        chk("lu_stall", e.id, 16'(lu_stall), 16'(e.lu));
        chk("flushing", e.id, 16'(flushing), 16'(e.fl));
        if (e.chk_pc)   chk("instr_pc", e.id, instr_pc, e.pc);
        if (e.chk_addr) chk("imem_addr", e.id, imem_addr, e.addr);
      end
    end
  end

  task automatic push(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                      input logic lu, input logic fl, input logic cp, input logic ca,
                      input logic [15:0] addr);
    exp_t x;
    x.instr = ins; x.pc = pc; x.addr = addr; x.vld = v; x.lu = lu; x.fl = fl;
    x.chk_pc = cp; x.chk_addr = ca; x.id = n_id;
    n_id++;
    exp_q.push_back(x);
  endtask

  task automatic step;
    @(posedge clk); #1;
    branch_taken = 1'b0;
  endtask

  task automatic tv(input logic [15:0] ins, input logic [15:0] pc);
    step; push(1'b1, ins, pc, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic tva(input logic [15:0] ins, input logic [15:0] pc, input logic [15:0] addr);
    step; push(1'b1, ins, pc, 1'b0, 1'b0, 1'b1, 1'b1, addr);
  endtask

  task automatic bub(input logic lu, input logic fl);
    step; push(1'b0, NOP, 16'h0, lu, fl, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic buba(input logic lu, input logic fl, input logic [15:0] addr);
    step; push(1'b0, NOP, 16'h0, lu, fl, 1'b0, 1'b1, addr);
  endtask

  task automatic br(input logic [15:0] t);
    branch_taken = 1'b1; branch_target = t;
  endtask

  task automatic rom_init;
    for (int i = 0; i < 65536; i++) rom[i] = i[15:0];
  endtask

  task automatic do_reset;
    step; rst = 1'b0;
    push(1'b0, NOP, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, PC_RST);
    step; rst = 1'b1;
  endtask

  task automatic rom_lw_add;
    rom_init;
    rom[16'h0010] = 16'h4080;   // lw r2
    rom[16'h0011] = 16'h0400;   // add reading rs=r2
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    branch_taken = 1'b0; branch_target = 16'h0;
    // Sequential stream, branch, branch during flush, PC wrap.
    rom_init;
    do_reset;
    buba(1'b0, 1'b0, 16'h0011);
    tv(16'h0010, 16'h0010); tv(16'h0011, 16'h0011); tv(16'h0012, 16'h0012); tv(16'h0013, 16'h0013);
    br(16'h0040);
    buba(1'b0, 1'b1, 16'h0040); buba(1'b0, 1'b1, 16'h0041);
    tv(16'h0040, 16'h0040); tv(16'h0041, 16'h0041); tv(16'h0042, 16'h0042);
    br(16'h0020); bub(1'b0, 1'b1);
    br(16'h0030); buba(1'b0, 1'b1, 16'h0030); buba(1'b0, 1'b1, 16'h0031);
    tv(16'h0030, 16'h0030); tv(16'h0031, 16'h0031);
    br(16'hFFFE);
    buba(1'b0, 1'b1, 16'hFFFE); buba(1'b0, 1'b1, 16'hFFFF);
    tva(16'hFFFE, 16'hFFFE, 16'h0000); tv(16'hFFFF, 16'hFFFF);
    tv(16'h0000, 16'h0000); tv(16'h0001, 16'h0001);

    // Load-use cases: rs hit, opcode 7 pass-through, r0 hit, addi rt miss.
    rom_lw_add;
    rom[16'h0014] = 16'h4000; rom[16'h0015] = 16'h7000;
    rom[16'h0016] = 16'h4000; rom[16'h0017] = 16'h0000;
    rom[16'h0018] = 16'h4080; rom[16'h0019] = 16'h14C0;
    do_reset;
    bub(1'b0, 1'b0);
    tv(16'h4080, 16'h0010);
`ifdef FD_LOAD_USE_STALL_EN
    buba(1'b1, 1'b0, 16'h0012);
`endif
    tv(16'h0400, 16'h0011); tv(16'h0012, 16'h0012); tv(16'h0013, 16'h0013);
    tv(16'h4000, 16'h0014); tv(16'h7000, 16'h0015); tv(16'h4000, 16'h0016);
`ifdef FD_LOAD_USE_STALL_EN
    bub(1'b1, 1'b0);
`endif
    tv(16'h0000, 16'h0017); tv(16'h4080, 16'h0018); tv(16'h14C0, 16'h0019); tv(16'h001A, 16'h001A);

    // Branch in the same cycle as a load-use hazard.
    rom_lw_add;
    do_reset;
    bub(1'b0, 1'b0);
    tv(16'h4080, 16'h0010);
    br(16'h0040);
    buba(1'b0, 1'b1, 16'h0040); bub(1'b0, 1'b1);
    tv(16'h0040, 16'h0040); tv(16'h0041, 16'h0041);

    // Branch arriving while the replay is pending.
    do_reset;
    bub(1'b0, 1'b0);
    tv(16'h4080, 16'h0010);
`ifdef FD_LOAD_USE_STALL_EN
    bub(1'b1, 1'b0);
`else
    tv(16'h0400, 16'h0011);
`endif
    br(16'h0050);
    bub(1'b0, 1'b1); bub(1'b0, 1'b1);
    tv(16'h0050, 16'h0050); tv(16'h0051, 16'h0051);

    // Asynchronous reset in the middle of the replay cycle, then restart.
    do_reset;
    bub(1'b0, 1'b0);
    tv(16'h4080, 16'h0010);
`ifdef FD_LOAD_USE_STALL_EN
    bub(1'b1, 1'b0);
`else
    tv(16'h0400, 16'h0011);
`endif
    @(negedge clk); #1;
    rst = 1'b0; #1;
    chk("async_instruction", n_id, instruction, NOP);
    chk("async_instr_valid", n_id, 16'(instr_valid), 16'h0);
    chk("async_lu_stall", n_id, 16'(lu_stall), 16'h0);
    chk("async_flushing", n_id, 16'(flushing), 16'h0);
    chk("async_instr_pc", n_id, instr_pc, 16'h0000);
    chk("async_imem_addr", n_id, imem_addr, PC_RST);
    @(posedge clk); #1;
    rst = 1'b1;
    bub(1'b0, 1'b0);
    tv(16'h4080, 16'h0010);
`ifdef FD_LOAD_USE_STALL_EN
    bub(1'b1, 1'b0);
`endif
    tv(16'h0400, 16'h0011); tv(16'h0012, 16'h0012);

    step; step;
    chk("queue_drained", n_id, 16'(exp_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
